// File: rtl/slice_frac_cc_cfg.sv
// Fracturable-LUT carry slice with serial configuration chain and load-tracking FSM.
// NUM_LUTS LUT_K-input LUTs feed a ripple P/G carry chain; each LUT output can
// select sum or raw LUT and pass through an optional output flop with an init value.
// Optional feature: define SLICE_CARRY_REG_EN to register the carry-out (co_o).
module slice_frac_cc_cfg #(
    parameter int unsigned LUT_K    = 4,
    parameter int unsigned NUM_LUTS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cfg_en_i,
    input  logic                        cfg_in_i,
    output logic                        cfg_out_o,
    output logic                        cfg_done_o,
    output logic                        cfg_err_o,
    input  logic [LUT_K*NUM_LUTS-1:0]   luts_in_i,
    input  logic                        ci_i,
    input  logic                        reg_ce_i,
    output logic [2*NUM_LUTS-1:0]       lut_out_o,
    output logic [NUM_LUTS-1:0]         slice_out_o,
    output logic                        co_o
);

    localparam int unsigned TT       = 2 ** LUT_K;
    localparam int unsigned W        = TT + 4;
    localparam int unsigned CFG_BITS = NUM_LUTS * W + 2;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 2);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(CFG_BITS);
    localparam logic [CNT_W-1:0] CntSat  = CNT_W'(CFG_BITS + 1);

    typedef enum logic [1:0] {StUncfg, StLoading, StActive} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [CFG_BITS-1:0]   cfg_q;
    logic [NUM_LUTS-1:0]   q_q;
    logic                  active;
    logic                  load_done;

    logic [NUM_LUTS-1:0]   lo, hi, s, d, init_v, reg_en_v;
    logic [NUM_LUTS:0]     c;
    logic [1:0]            cin_sel;

    assign active     = (state_q == StActive);
    assign load_done  = (state_q == StLoading) && !cfg_en_i && (cnt_q == CntFull);
    assign cfg_out_o  = cfg_q[CFG_BITS-1];
    assign cfg_done_o = active;
    assign cfg_err_o  = err_q;
    assign cin_sel    = cfg_q[CFG_BITS-1:CFG_BITS-2];

    // Serial config shift register; first bit in ends up at the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else if (cfg_en_i) begin
            cfg_q <= {cfg_q[CFG_BITS-2:0], cfg_in_i};
        end
    end

    // Load-tracking state, bit counter and error flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StUncfg;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: entry cycle counts its own shifted bit, so a full load ends at CntFull.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (cfg_en_i) begin
            state_d = StLoading;
            if (state_q != StLoading) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CntSat) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q == StLoading) begin
            if (cnt_q == CntFull) begin
                state_d = StActive;
                err_d   = 1'b0;
            end else begin
                state_d = StUncfg;
                err_d   = 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        logic [TT-1:0]    tt;
        logic [LUT_K-1:0] addr;
        logic [LUT_K-2:0] a;
        logic             frac;
        logic             sel_sum;

        assign tt          = cfg_q[i*W +: TT];
        assign frac        = cfg_q[i*W + TT];
        assign sel_sum     = cfg_q[i*W + TT + 1];
        assign reg_en_v[i] = cfg_q[i*W + TT + 2];
        assign init_v[i]   = cfg_q[i*W + TT + 3];
        assign addr        = luts_in_i[i*LUT_K +: LUT_K];
        assign a           = addr[LUT_K-2:0];

        // Fractured mode splits the table into two (K-1)-input halves.
        assign lo[i] = frac ? tt[{1'b0, a}] : tt[addr];
        assign hi[i] = frac & tt[{1'b1, a}];
        assign d[i]  = sel_sum ? s[i] : lo[i];

        assign lut_out_o[2*i +: 2] = active ? {hi[i], lo[i]} : 2'b00;
        assign slice_out_o[i]      = active & (reg_en_v[i] ? q_q[i] : d[i]);
    end

    // Ripple carry chain: P = lo, G = hi.
    always_comb begin
        unique case (cin_sel)
            2'b01:   c[0] = 1'b0;
            2'b10:   c[0] = 1'b1;
            default: c[0] = ci_i;
        endcase
        for (int i = 0; i < NUM_LUTS; i++) begin
            c[i+1] = hi[i] | (lo[i] & c[i]);
            s[i]   = lo[i] ^ c[i];
        end
    end

    // Output flops: preset to init on the load-complete edge, else capture d when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (load_done) begin
            q_q <= init_v;
        end else if (active && reg_ce_i) begin
            q_q <= d;
        end
    end

`ifdef SLICE_CARRY_REG_EN
    logic co_q;

    // Registered carry-out, cleared whenever the slice is not active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            co_q <= 1'b0;
        end else begin
            co_q <= active & c[NUM_LUTS];
        end
    end

    assign co_o = active & co_q;
`else
    assign co_o = active & c[NUM_LUTS];
`endif

endmodule

// File: tb/tb_slice_frac_cc_cfg.sv
// Directed, table-driven bench for slice_frac_cc_cfg at default parameters.
module tb_slice_frac_cc_cfg;

    localparam int K  = 4;
    localparam int N  = 4;
    localparam int W  = 20;
    localparam int CB = 82;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           cfg_en = 1'b0;
    logic           cfg_in = 1'b0;
    logic           ci = 1'b0;
    logic           reg_ce = 1'b0;
    logic [K*N-1:0] luts_in = '0;
    logic           cfg_out, cfg_done, cfg_err, co;
    logic [2*N-1:0] lut_out;
    logic [N-1:0]   slice_out;

    int n_cmp  = 0;
    int n_fail = 0;

    slice_frac_cc_cfg #(.LUT_K(K), .NUM_LUTS(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_en_i    (cfg_en),
        .cfg_in_i    (cfg_in),
        .cfg_out_o   (cfg_out),
        .cfg_done_o  (cfg_done),
        .cfg_err_o   (cfg_err),
        .luts_in_i   (luts_in),
        .ci_i        (ci),
        .reg_ce_i    (reg_ce),
        .lut_out_o   (lut_out),
        .slice_out_o (slice_out),
        .co_o        (co)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] sum;
        logic       cout;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [CB-1:0] mk_cfg(input logic [15:0] tt, input logic frac,
                                             input logic sel_sum, input logic reg_en,
                                             input logic init, input logic [N-1:0] mask,
                                             input logic [1:0] cin_sel);
        logic [CB-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (mask[i]) v[i*W +: W] = {init, reg_en, sel_sum, frac, tt};
        end
        v[CB-1 -: 2] = cin_sel;
        return v;
    endfunction

    // A bit on address bit 0, B bit on address bit 1 of each LUT.
    function automatic logic [K*N-1:0] ab(input logic [3:0] a, input logic [3:0] b);
        logic [K*N-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            r[i*K]     = a[i];
            r[i*K + 1] = b[i];
        end
        return r;
    endfunction

    // Shift nbits (MSB of v first; extra leading bits are 0), then release cfg_en for one edge.
    task automatic load(input logic [CB-1:0] v, input int nbits);
        for (int j = nbits - 1; j >= 0; j--) begin
            cfg_en = 1'b1;
            cfg_in = (j < CB) ? v[j] : 1'b0;
            @(posedge clk); #1;
        end
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CB-1:0]  cfg;
        logic [2*N-1:0] exp_lo;

        tbl[0] = '{4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
        tbl[1] = '{4'h3, 4'h5, 1'b0, 4'h8, 1'b0};
        tbl[2] = '{4'hF, 4'h1, 1'b0, 4'h0, 1'b1};
        tbl[3] = '{4'hF, 4'hF, 1'b1, 4'hF, 1'b1};
        tbl[4] = '{4'h7, 4'h8, 1'b1, 4'h0, 1'b1};
        tbl[5] = '{4'hA, 4'h5, 1'b0, 4'hF, 1'b0};
        tbl[6] = '{4'h9, 4'h6, 1'b1, 4'h0, 1'b1};
        tbl[7] = '{4'h2, 4'h2, 1'b1, 4'h5, 1'b0};

        // Reset state
        #12;
        check("rst_done", cfg_done, 0);
        check("rst_err", cfg_err, 0);
        check("rst_slice", slice_out, 0);
        check("rst_co", co, 0);
        check("rst_cfg_out", cfg_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All-ones load: every flop inits to 1
        load('1, CB);
        check("ones_done", cfg_done, 1);
        check("ones_slice", slice_out, 4'hF);
        check("ones_cfg_out", cfg_out, 1);

        // Short load leaves the chain full of ones but flags an error
        load('1, CB - 1);
        check("ones_short_err", cfg_err, 1);
        check("ones_short_done", cfg_done, 0);

        // Asynchronous reset in the middle of a load
        cfg_en = 1'b1;
        cfg_in = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        #1 rst_n = 1'b0;
        #1;
        check("midrst_cfg_out", cfg_out, 0);
        check("midrst_done", cfg_done, 0);
        check("midrst_err", cfg_err, 0);
        check("midrst_slice", slice_out, 0);
        check("midrst_co", co, 0);
        cfg_en = 1'b0;
        cfg_in = 1'b0;
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // LUT0 as 4-input AND
        cfg = mk_cfg(16'h8000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 2'b00);
        load(cfg, CB);
        check("and_done", cfg_done, 1);
        check("and_err", cfg_err, 0);
        luts_in = 16'h000F; #1;
        check("and_F", slice_out, 4'h1);
        luts_in = 16'h000E; #1;
        check("and_E", slice_out, 4'h0);

        // Short load: error, outputs forced low
        luts_in = 16'h000F;
        load(cfg, CB - 1);
        check("short_err", cfg_err, 1);
        check("short_done", cfg_done, 0);
        check("short_slice", slice_out, 0);
        check("short_lut_out", lut_out, 0);
        check("short_co", co, 0);

        // Good reload clears the error; then a long load sets it again
        load(cfg, CB);
        check("reload_done", cfg_done, 1);
        check("reload_err", cfg_err, 0);
        check("reload_slice", slice_out, 4'h1);
        load(cfg, CB + 1);
        check("long_err", cfg_err, 1);
        check("long_done", cfg_done, 0);
        check("long_slice", slice_out, 0);

        // Adder table, carry-in taken from ci
        cfg = mk_cfg(16'h8866, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 2'b00);
        load(cfg, CB);
        foreach (tbl[t]) begin
            luts_in = ab(tbl[t].a, tbl[t].b);
            ci      = tbl[t].cin;
            for (int i = 0; i < N; i++) begin
                exp_lo[2*i]     = tbl[t].a[i] ^ tbl[t].b[i];
                exp_lo[2*i + 1] = tbl[t].a[i] & tbl[t].b[i];
            end
            @(posedge clk); #1;
            check($sformatf("add%0d_sum", t), slice_out, tbl[t].sum);
            check($sformatf("add%0d_co", t), co, tbl[t].cout);
            check($sformatf("add%0d_lut_out", t), lut_out, exp_lo);
        end

        // Adder with constant-0 carry-in; ci=1 must be ignored
        cfg = mk_cfg(16'h8866, 1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 2'b01);
        ci = 1'b1;
        luts_in = '0;
        load(cfg, CB);
        check("c0_co_idle", co, 0);
        luts_in = ab(4'hB, 4'h6); #1;
        check("c0_sum", slice_out, 4'h1);
`ifdef SLICE_CARRY_REG_EN
        check("c0_co_before_edge", co, 0);
`else
        check("c0_co_comb", co, 1);
`endif
        @(posedge clk); #1;
        check("c0_co_after_edge", co, 1);
        ci = 1'b0;

        // Output flop: init 1, hold with reg_ce=0, capture d=0 with reg_ce=1
        cfg = mk_cfg(16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 2'b00);
        luts_in = '0;
        reg_ce = 1'b0;
        load(cfg, CB);
        check("flop_init", slice_out, 4'h1);
        @(posedge clk); #1;
        check("flop_hold", slice_out, 4'h1);
        reg_ce = 1'b1;
        @(posedge clk); #1;
        check("flop_capture", slice_out, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
